// File: rtl/maze_path_controller.sv
`default_nettype none
// ============================================================================
// Module      : maze_path_controller
// Description : Depth-first maze search sequencer. Walks from (0,0) toward
//               (N-1,N-1), pushing accepted moves onto an external 2-bit
//               move stack, popping on dead ends, and marking visited cells
//               in an external 1-bit-per-cell maze memory.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_path_controller #(
   parameter int N           = 16,
   parameter int CW          = $clog2(N),
   parameter int STACK_DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          no_path,
   output logic          overflow,
   output logic [8:0]    path_len,
   output logic [CW-1:0] mem_x,
   output logic [CW-1:0] mem_y,
   output logic          mem_rd,
   input  logic          mem_data,
   output logic          mem_wr,
   output logic          mem_wdata,
   output logic          stk_push,
   output logic          stk_pop,
   output logic [1:0]    stk_move,
   input  logic [1:0]    stk_top,
   input  logic          stk_empty,
   input  logic          stk_full
);

   localparam logic [CW-1:0] c_one  = CW'(1);
   localparam logic [CW-1:0] c_maxc = CW'(N - 1);
   localparam logic [8:0]    c_cap  = 9'(STACK_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MARK      = 3'd1,
      S_PROBE     = 3'd2,
      S_CHECK     = 3'd3,
      S_BACKTRACK = 3'd4,
      S_DONE      = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   state_t        r_state, w_state_n;
   logic [CW-1:0] r_pos_x, r_pos_y, w_pos_x_n, w_pos_y_n;
   logic [1:0]    r_dir, w_dir_n;
   logic [8:0]    r_len, w_len_n;
   logic          r_ovf, w_ovf_n;

   logic [CW-1:0] w_nb_x, w_nb_y;
   logic          w_nb_oob;
   logic [CW-1:0] w_bk_x, w_bk_y;
   logic          w_full;
   logic          w_at_goal;

   // Neighbor of the current position in the current direction, with bounds check
   always_comb begin
      w_nb_x   = r_pos_x;
      w_nb_y   = r_pos_y;
      w_nb_oob = 1'b0;
      case (r_dir)
         2'd0: if (r_pos_y == '0)   w_nb_oob = 1'b1; else w_nb_y = r_pos_y - c_one;
         2'd1: if (r_pos_x == c_maxc) w_nb_oob = 1'b1; else w_nb_x = r_pos_x + c_one;
         2'd2: if (r_pos_y == c_maxc) w_nb_oob = 1'b1; else w_nb_y = r_pos_y + c_one;
         default: if (r_pos_x == '0) w_nb_oob = 1'b1; else w_nb_x = r_pos_x - c_one;
      endcase
   end

   // Position reached by undoing the move on top of the stack
   always_comb begin
      w_bk_x = r_pos_x;
      w_bk_y = r_pos_y;
      case (stk_top)
         2'd0:    w_bk_y = r_pos_y + c_one;
         2'd1:    w_bk_x = r_pos_x - c_one;
         2'd2:    w_bk_y = r_pos_y - c_one;
         default: w_bk_x = r_pos_x + c_one;
      endcase
   end

   // Local occupancy guard backs up the stack's own full flag
   assign w_full    = stk_full || (r_len >= c_cap);
   assign w_at_goal = (r_pos_x == c_maxc) && (r_pos_y == c_maxc);

   // Next-state, register updates and strobe decode
   always_comb begin
      w_state_n = r_state;
      w_pos_x_n = r_pos_x;
      w_pos_y_n = r_pos_y;
      w_dir_n   = r_dir;
      w_len_n   = r_len;
      w_ovf_n   = r_ovf;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_x     = '0;
      mem_y     = '0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_move  = 2'd0;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               w_state_n = S_MARK;
               w_pos_x_n = '0;
               w_pos_y_n = '0;
               w_dir_n   = 2'd0;
               w_ovf_n   = 1'b0;
            end
         end
         S_MARK: begin
            mem_wr = 1'b1;
            mem_x  = r_pos_x;
            mem_y  = r_pos_y;
            if (w_at_goal) begin
               w_state_n = S_DONE;
            end else begin
               w_dir_n   = 2'd0;
               w_state_n = S_PROBE;
            end
         end
         S_PROBE: begin
            if (w_nb_oob) begin
               if (r_dir == 2'd3) w_state_n = S_BACKTRACK;
               else               w_dir_n   = r_dir + 2'd1;
            end else begin
               mem_rd    = 1'b1;
               mem_x     = w_nb_x;
               mem_y     = w_nb_y;
               w_state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!mem_data) begin
               if (w_full) begin
                  w_ovf_n   = 1'b1;
                  w_state_n = S_FAIL;
               end else begin
                  stk_push  = 1'b1;
                  stk_move  = r_dir;
                  w_pos_x_n = w_nb_x;
                  w_pos_y_n = w_nb_y;
                  w_len_n   = r_len + 9'd1;
                  w_state_n = S_MARK;
               end
            end else if (r_dir == 2'd3) begin
               w_state_n = S_BACKTRACK;
            end else begin
               w_dir_n   = r_dir + 2'd1;
               w_state_n = S_PROBE;
            end
         end
         S_BACKTRACK: begin
            if (stk_empty) begin
               w_state_n = S_FAIL;
            end else begin
               stk_pop   = 1'b1;
               w_pos_x_n = w_bk_x;
               w_pos_y_n = w_bk_y;
               w_len_n   = r_len - 9'd1;
               // A popped left move exhausts that cell; keep popping.
               if (stk_top != 2'd3) begin
                  w_dir_n   = stk_top + 2'd1;
                  w_state_n = S_PROBE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      // No memory or stack traffic may escape during reset.
      if (rst) begin
         mem_rd   = 1'b0;
         mem_wr   = 1'b0;
         mem_x    = '0;
         mem_y    = '0;
         stk_push = 1'b0;
         stk_pop  = 1'b0;
         stk_move = 2'd0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pos_x <= '0;
         r_pos_y <= '0;
         r_dir   <= 2'd0;
         r_len   <= 9'd0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pos_x <= w_pos_x_n;
         r_pos_y <= w_pos_y_n;
         r_dir   <= w_dir_n;
         r_len   <= w_len_n;
         r_ovf   <= w_ovf_n;
      end
   end

   assign busy      = (r_state == S_MARK) || (r_state == S_PROBE) ||
                      (r_state == S_CHECK) || (r_state == S_BACKTRACK);
   assign done      = (r_state == S_DONE);
   assign no_path   = (r_state == S_FAIL);
   assign overflow  = r_ovf;
   assign path_len  = r_len;
   assign mem_wdata = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_maze_path_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_path_controller
// Description : Directed bench for maze_path_controller on a 4x4 maze with a
//               behavioural maze memory and move stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_path_controller;

   localparam int N  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, no_path, overflow;
   logic [8:0]    path_len;
   logic [CW-1:0] mem_x, mem_y;
   logic          mem_rd, mem_wr, mem_wdata;
   logic          mem_data;
   logic          stk_push, stk_pop;
   logic [1:0]    stk_move;
   logic [1:0]    stk_top;
   logic          stk_empty, stk_full;

   // environment models
   logic [15:0] maze;
   logic [15:0] maze_pat = 16'h0;
   int          depth_lim = 256;
   logic        env_init = 1'b0;
   logic [1:0]  stk [0:255];
   int          scount;
   int          push_cnt, pop_cnt;
   logic [31:0] hist;
   logic        both_seen;

   int n_pass = 0;
   int n_total = 0;
   int cyc;

   maze_path_controller #(.N(N), .STACK_DEPTH(256)) dut (
      .clk(clk), .rst(rst), .start(start),
      .busy(busy), .done(done), .no_path(no_path), .overflow(overflow),
      .path_len(path_len), .mem_x(mem_x), .mem_y(mem_y),
      .mem_rd(mem_rd), .mem_data(mem_data), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_move(stk_move),
      .stk_top(stk_top), .stk_empty(stk_empty), .stk_full(stk_full)
   );

   always #5 clk = ~clk;

   // maze memory: registered read, write marks visited
   always @(posedge clk) begin
      if (env_init) begin
         maze     <= maze_pat;
         mem_data <= 1'b0;
      end else begin
         if (mem_wr && mem_wdata) maze[{mem_y, mem_x}] <= 1'b1;
         if (mem_rd) mem_data <= maze[{mem_y, mem_x}];
      end
   end

   // move stack
   assign stk_empty = (scount == 0);
   assign stk_full  = (scount >= depth_lim);
   assign stk_top   = (scount > 0) ? stk[scount-1] : 2'd0;

   always @(posedge clk) begin
      if (env_init) begin
         scount    <= 0;
         push_cnt  <= 0;
         pop_cnt   <= 0;
         hist      <= 32'h0;
         both_seen <= 1'b0;
      end else begin
         if (stk_push && stk_pop) both_seen <= 1'b1;
         if (stk_push) begin
            stk[scount] <= stk_move;
            scount      <= scount + 1;
            push_cnt    <= push_cnt + 1;
            hist        <= {hist[29:0], stk_move};
         end else if (stk_pop) begin
            scount  <= scount - 1;
            pop_cnt <= pop_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic env_setup(input logic [15:0] pat, input int lim);
      maze_pat  = pat;
      depth_lim = lim;
      env_init  = 1'b1;
      @(posedge clk); @(negedge clk);
      env_init  = 1'b0;
   endtask

   // Drive start for one cycle; returns at the negedge of the first busy cycle.
   task automatic start_search();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
   endtask

   // Run until done/no_path or the budget; optional extra start pulse at cycle pulse_at.
   task automatic run(input int budget, input int pulse_at, inout int c);
      while (!done && !no_path && c < budget) begin
         @(posedge clk); @(negedge clk);
         c++;
         start = (c == pulse_at);
      end
      start = 1'b0;
   endtask

   initial begin
      env_setup(16'h0, 256);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_status", {busy, done, no_path, overflow}, 32'h0);
      check("rst_len", path_len, 32'h0);
      check("rst_strobes", {mem_rd, mem_wr, stk_push, stk_pop, stk_move, mem_x, mem_y}, 32'h0);

      // test 1: free maze
      env_setup(16'h0000, 256);
      start_search();
      check("t1_first_mark", {busy, mem_wr, mem_x, mem_y}, 32'b1100_00);
      cyc = 1;
      run(500, 0, cyc);
      check("t1_done_cycle", cyc, 31);
      check("t1_status", {done, no_path, overflow, busy}, 32'b1000);
      check("t1_len", path_len, 6);
      check("t1_moves", hist, 32'h56A);
      check("t1_stack", scount, 6);

      // test 2: walled in
      rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
      env_setup(16'hFFFE, 256);
      start_search();
      cyc = 1;
      run(500, 0, cyc);
      check("t2_fail_cycle", cyc, 9);
      check("t2_status", {done, no_path, overflow}, 32'b010);
      check("t2_pushpop", {push_cnt[7:0], pop_cnt[7:0]}, 32'h0);
      check("t2_len", path_len, 0);

      // test 3: dead-end corridor, full unwind
      env_setup(16'h4222, 256);
      start_search();
      cyc = 1;
      run(500, 0, cyc);
      check("t3_status", {done, no_path, overflow}, 32'b010);
      check("t3_moves", hist, 32'hA9);
      check("t3_pushes", push_cnt, 4);
      check("t3_pops", pop_cnt, 4);
      check("t3_empty", stk_empty, 1);
      check("t3_len", path_len, 0);

      // test 4: stack full after 4 pushes
      env_setup(16'h0000, 4);
      start_search();
      cyc = 1;
      run(500, 0, cyc);
      check("t4_status", {done, no_path, overflow}, 32'b011);
      check("t4_len", path_len, 4);
      check("t4_moves", hist, 32'h56);
      check("t4_pushes", push_cnt, 4);

      // test 5: reset mid-search, then rerun
      env_setup(16'h0000, 256);
      start_search();
      cyc = 1;
      run(10, 0, cyc);
      check("t5_running", {busy, done, no_path}, 32'b100);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("t5_rst_strobes", {busy, mem_rd, mem_wr, stk_push, stk_pop}, 32'h0);
      check("t5_rst_len", path_len, 0);
      rst = 1'b0;
      env_setup(16'h0000, 256);
      start_search();
      cyc = 1;
      run(500, 0, cyc);
      check("t5_done_cycle", cyc, 31);
      check("t5_status", {done, no_path, overflow}, 32'b100);
      check("t5_moves", hist, 32'h56A);

      // test 6: start while busy is ignored; start in DONE clears done
      rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
      env_setup(16'h0000, 256);
      start_search();
      cyc = 1;
      run(500, 5, cyc);
      check("t6_done_cycle", cyc, 31);
      check("t6_status", {done, no_path, overflow}, 32'b100);
      check("t6_moves", hist, 32'h56A);
      check("t6_len", path_len, 6);
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("t6_restart", {done, busy, mem_wr}, 32'b011);

      check("never_push_and_pop", both_seen, 0);

      rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
